// File: rtl/eth_rx_frame_mgr_pkg.sv
// rtl/eth_rx_frame_mgr_pkg.sv - shared states, slot defaults and Ethernet field sizes
package eth_rx_pkg;

   localparam int NUM_SLOTS_DEF   = 4;
   localparam int SLOT_IDX_W_DEF  = 2;
   localparam int SLOT_ADDR_W_DEF = 11;
   localparam int LEN_W_DEF       = 16;

   localparam int MAC_BYTES       = 6;
   localparam int LEN_TYPE_BYTES  = 2;
   localparam int FCS_BYTES       = 4;
   localparam int IPG_BYTES       = 12;
   localparam int MIN_FRAME_BYTES = 2 * MAC_BYTES + LEN_TYPE_BYTES + 46 + FCS_BYTES;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WRITE   = 2'd1,
      S_DISCARD = 2'd2,
      S_COMMIT  = 2'd3
   } rx_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/eth_rx_frame_mgr_if.sv
// rtl/eth_rx_frame_mgr_if.sv - RX byte path, buffer RAM write port, consumer handshake and stats
interface eth_rx_frame_mgr_if
   import eth_rx_pkg::*;
#(
   parameter int pSLOT_IDX_W  = SLOT_IDX_W_DEF,
   parameter int pSLOT_ADDR_W = SLOT_ADDR_W_DEF,
   parameter int pLEN_W       = LEN_W_DEF
);
   logic                                Rx_Frame_Start;
   logic                                Rx_Byte_Rdy;
   logic [7:0]                          Rx_Byte;
   logic                                Rx_Frame_End;
   logic                                Crc_Ok;
   logic                                Wr_En;
   logic [pSLOT_IDX_W+pSLOT_ADDR_W-1:0] Wr_Addr;
   logic [7:0]                          Wr_Data;
   logic                                Frm_Avail;
   logic [pSLOT_IDX_W-1:0]              Frm_Slot;
   logic [pLEN_W-1:0]                   Frm_Len;
   logic                                Frm_Ack;
   logic                                Drop;
   logic [15:0]                         Good_Cnt;
   logic [15:0]                         Crc_Drop_Cnt;
   logic [15:0]                         Full_Drop_Cnt;
   logic [15:0]                         Ovf_Drop_Cnt;

   modport master (
      input  Rx_Frame_Start, Rx_Byte_Rdy, Rx_Byte, Rx_Frame_End, Crc_Ok, Frm_Ack,
      output Wr_En, Wr_Addr, Wr_Data, Frm_Avail, Frm_Slot, Frm_Len, Drop,
             Good_Cnt, Crc_Drop_Cnt, Full_Drop_Cnt, Ovf_Drop_Cnt
   );

   modport slave (
      output Rx_Frame_Start, Rx_Byte_Rdy, Rx_Byte, Rx_Frame_End, Crc_Ok, Frm_Ack,
      input  Wr_En, Wr_Addr, Wr_Data, Frm_Avail, Frm_Slot, Frm_Len, Drop,
             Good_Cnt, Crc_Drop_Cnt, Full_Drop_Cnt, Ovf_Drop_Cnt
   );
endinterface

// File: rtl/eth_rx_slot_fifo.sv
// rtl/eth_rx_slot_fifo.sv - slot ring: write/read pointers, occupancy, per-slot frame lengths
module eth_rx_slot_fifo
   import eth_rx_pkg::*;
#(
   parameter int pNUM_SLOTS  = NUM_SLOTS_DEF,
   parameter int pSLOT_IDX_W = SLOT_IDX_W_DEF,
   parameter int pLEN_W      = LEN_W_DEF
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   commit_i,
   input  logic [pLEN_W-1:0]      commit_len_i,
   input  logic                   ack_i,
   output logic [pSLOT_IDX_W-1:0] wr_slot_o,
   output logic                   slot_free_o,
   output logic                   avail_o,
   output logic [pSLOT_IDX_W-1:0] rd_slot_o,
   output logic [pLEN_W-1:0]      len_o
);
   logic [pSLOT_IDX_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [pSLOT_IDX_W:0]   occ_q, occ_d;
   logic                   avail_q;
   logic [pLEN_W-1:0]      len_q [pNUM_SLOTS];
   logic                   ack_ok;

   assign ack_ok = ack_i & avail_q;

   always_comb begin
      occ_d = occ_q;
      case ({commit_i, ack_ok})
         2'b10:   occ_d = occ_q + (pSLOT_IDX_W+1)'(1);
         2'b01:   occ_d = occ_q - (pSLOT_IDX_W+1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   // pointers are exactly log2(slots) wide, so increment wraps the ring
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         avail_q  <= 1'b0;
         for (int i = 0; i < pNUM_SLOTS; i++) len_q[i] <= '0;
      end else begin
         if (commit_i) begin
            len_q[wr_ptr_q] <= commit_len_i;
            wr_ptr_q        <= wr_ptr_q + pSLOT_IDX_W'(1);
         end
         if (ack_ok) rd_ptr_q <= rd_ptr_q + pSLOT_IDX_W'(1);
         occ_q   <= occ_d;
         avail_q <= (occ_d != '0);
      end
   end

   assign wr_slot_o   = wr_ptr_q;
   assign slot_free_o = (occ_q < (pSLOT_IDX_W+1)'(pNUM_SLOTS));
   assign avail_o     = avail_q;
   assign rd_slot_o   = rd_ptr_q;
   assign len_o       = len_q[rd_ptr_q];
endmodule

// File: rtl/eth_rx_frame_mgr.sv
// rtl/eth_rx_frame_mgr.sv - RX frame slot manager; statistics counters under ETH_RX_FRAME_STATS_EN
module eth_rx_frame_mgr
   import eth_rx_pkg::*;
#(
   parameter int pNUM_SLOTS   = NUM_SLOTS_DEF,
   parameter int pSLOT_IDX_W  = SLOT_IDX_W_DEF,
   parameter int pSLOT_ADDR_W = SLOT_ADDR_W_DEF,
   parameter int pLEN_W       = LEN_W_DEF
) (
   input  logic               Clk,
   input  logic               Rst_n,
   eth_rx_frame_mgr_if.master bus
);
   localparam int CNT_W  = pSLOT_ADDR_W + 1;
   localparam int ADDR_W = pSLOT_IDX_W + pSLOT_ADDR_W;

   rx_state_e              state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
   logic [7:0]             wr_data_q, wr_data_d;
   logic                   drop_q, drop_d;
   logic                   good_inc, crc_inc, full_inc, ovf_inc;
   logic                   commit;
   logic [pSLOT_IDX_W-1:0] wr_slot;
   logic                   slot_free;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      drop_d    = 1'b0;
      good_inc  = 1'b0;
      crc_inc   = 1'b0;
      full_inc  = 1'b0;
      ovf_inc   = 1'b0;
      commit    = 1'b0;
      case (state_q)
         S_IDLE, S_DISCARD: begin
            if (bus.Rx_Frame_Start) begin
               if (slot_free) begin
                  state_d = S_WRITE;
                  count_d = '0;
               end else begin
                  state_d  = S_DISCARD;
                  full_inc = 1'b1;
                  drop_d   = 1'b1;
               end
            end else if (state_q == S_DISCARD && bus.Rx_Frame_End) begin
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            if (bus.Rx_Frame_Start) begin
               count_d = '0;
            end else begin
               if (bus.Rx_Byte_Rdy) begin
                  // count MSB set means the slot is already full
                  if (!count_q[CNT_W-1]) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = {wr_slot, count_q[pSLOT_ADDR_W-1:0]};
                     wr_data_d = bus.Rx_Byte;
                     count_d   = count_q + CNT_W'(1);
                  end else begin
                     state_d = S_DISCARD;
                     ovf_inc = 1'b1;
                     drop_d  = 1'b1;
                  end
               end
               if (bus.Rx_Frame_End) begin
                  if (ovf_inc) begin
                     state_d = S_IDLE;
                  end else if (bus.Crc_Ok) begin
                     state_d = S_COMMIT;
                  end else begin
                     state_d = S_IDLE;
                     crc_inc = 1'b1;
                     drop_d  = 1'b1;
                  end
               end
            end
         end
         S_COMMIT: begin
            commit   = 1'b1;
            good_inc = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         drop_q    <= drop_d;
      end
   end

   eth_rx_slot_fifo #(
      .pNUM_SLOTS  (pNUM_SLOTS),
      .pSLOT_IDX_W (pSLOT_IDX_W),
      .pLEN_W      (pLEN_W)
   ) u_slot_fifo (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .commit_i     (commit),
      .commit_len_i (pLEN_W'(count_q)),
      .ack_i        (bus.Frm_Ack),
      .wr_slot_o    (wr_slot),
      .slot_free_o  (slot_free),
      .avail_o      (bus.Frm_Avail),
      .rd_slot_o    (bus.Frm_Slot),
      .len_o        (bus.Frm_Len)
   );

   assign bus.Wr_En   = wr_en_q;
   assign bus.Wr_Addr = wr_addr_q;
   assign bus.Wr_Data = wr_data_q;
   assign bus.Drop    = drop_q;

`ifdef ETH_RX_FRAME_STATS_EN
   logic [15:0] good_cnt_q, crc_cnt_q, full_cnt_q, ovf_cnt_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         good_cnt_q <= '0;
         crc_cnt_q  <= '0;
         full_cnt_q <= '0;
         ovf_cnt_q  <= '0;
      end else begin
         if (good_inc) good_cnt_q <= sat_inc16(good_cnt_q);
         if (crc_inc)  crc_cnt_q  <= sat_inc16(crc_cnt_q);
         if (full_inc) full_cnt_q <= sat_inc16(full_cnt_q);
         if (ovf_inc)  ovf_cnt_q  <= sat_inc16(ovf_cnt_q);
      end
   end

   assign bus.Good_Cnt      = good_cnt_q;
   assign bus.Crc_Drop_Cnt  = crc_cnt_q;
   assign bus.Full_Drop_Cnt = full_cnt_q;
   assign bus.Ovf_Drop_Cnt  = ovf_cnt_q;
`else
   logic unused_stats;
   assign unused_stats      = ^{good_inc, crc_inc, full_inc, ovf_inc};
   assign bus.Good_Cnt      = 16'h0;
   assign bus.Crc_Drop_Cnt  = 16'h0;
   assign bus.Full_Drop_Cnt = 16'h0;
   assign bus.Ovf_Drop_Cnt  = 16'h0;
`endif
endmodule

// File: tb/tb_eth_rx_frame_mgr.sv
// tb/tb_eth_rx_frame_mgr.sv - directed frame vectors plus commit/ack and reset corner sequences
module tb_eth_rx_frame_mgr;
   import eth_rx_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #10 clk = ~clk;

   eth_rx_frame_mgr_if #(.pSLOT_IDX_W(2), .pSLOT_ADDR_W(11), .pLEN_W(16)) bus ();

   eth_rx_frame_mgr #(
      .pNUM_SLOTS(4), .pSLOT_IDX_W(2), .pSLOT_ADDR_W(11), .pLEN_W(16)
   ) dut (
      .Clk   (clk),
      .Rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   int wr_addr_log[$];
   int wr_data_log[$];
   int drop_total = 0;

   always @(negedge clk) begin
      if (bus.Wr_En) begin
         wr_addr_log.push_back(int'(bus.Wr_Addr));
         wr_data_log.push_back(int'(bus.Wr_Data));
      end
      if (bus.Drop) drop_total++;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int stat_exp(input int n);
`ifdef ETH_RX_FRAME_STATS_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_pulse();
      bus.Frm_Ack = 1'b1;
      tick();
      bus.Frm_Ack = 1'b0;
      tick();
   endtask

   task automatic send_frame(input int len, input bit crc, input bit ack_in_commit);
      bus.Rx_Frame_Start = 1'b1;
      tick();
      bus.Rx_Frame_Start = 1'b0;
      for (int i = 0; i < len; i++) begin
         bus.Rx_Byte_Rdy = 1'b1;
         bus.Rx_Byte     = 8'(i) ^ 8'hA5;
         tick();
      end
      bus.Rx_Byte_Rdy  = 1'b0;
      bus.Rx_Frame_End = 1'b1;
      bus.Crc_Ok       = crc;
      tick();
      bus.Rx_Frame_End = 1'b0;
      bus.Crc_Ok       = 1'b0;
      bus.Frm_Ack      = ack_in_commit;
      tick();
      bus.Frm_Ack      = 1'b0;
      repeat (3) tick();
   endtask

   task automatic chk_counters(input string tag, input int g, input int c, input int f, input int o);
      chk({tag, ".good"}, int'(bus.Good_Cnt), stat_exp(g));
      chk({tag, ".crc"},  int'(bus.Crc_Drop_Cnt), stat_exp(c));
      chk({tag, ".full"}, int'(bus.Full_Drop_Cnt), stat_exp(f));
      chk({tag, ".ovf"},  int'(bus.Ovf_Drop_Cnt), stat_exp(o));
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, ".wr_en"},   int'(bus.Wr_En), 0);
      chk({tag, ".wr_addr"}, int'(bus.Wr_Addr), 0);
      chk({tag, ".wr_data"}, int'(bus.Wr_Data), 0);
      chk({tag, ".avail"},   int'(bus.Frm_Avail), 0);
      chk({tag, ".slot"},    int'(bus.Frm_Slot), 0);
      chk({tag, ".len"},     int'(bus.Frm_Len), 0);
      chk({tag, ".drop"},    int'(bus.Drop), 0);
      chk_counters(tag, 0, 0, 0, 0);
   endtask

   typedef struct {
      int len;
      bit crc;
      int acks;
      int exp_wr;
      int exp_first;
      int exp_last;
      int exp_avail;
      int exp_slot;
      int exp_len;
      int exp_drops;
      int exp_good;
      int exp_crc;
      int exp_full;
      int exp_ovf;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int wr0, dr0, n_wr;

      //            len   crc acks  wr    first    last     av sl len  dr  g  c  f  o
      vecs[0] = '{64,   1'b0, 0, 64,   'h000,  'h03F,   0, 0, 0,   1, 0, 1, 0, 0};
      vecs[1] = '{64,   1'b1, 0, 64,   'h000,  'h03F,   1, 0, 64,  0, 1, 1, 0, 0};
      vecs[2] = '{65,   1'b1, 0, 65,   'h800,  'h840,   1, 0, 64,  0, 2, 1, 0, 0};
      vecs[3] = '{66,   1'b1, 0, 66,   'h1000, 'h1041,  1, 0, 64,  0, 3, 1, 0, 0};
      vecs[4] = '{67,   1'b1, 0, 67,   'h1800, 'h1842,  1, 0, 64,  0, 4, 1, 0, 0};
      vecs[5] = '{64,   1'b1, 0, 0,    0,      0,       1, 0, 64,  1, 4, 1, 1, 0};
      vecs[6] = '{68,   1'b1, 1, 68,   'h000,  'h043,   1, 1, 65,  0, 5, 1, 1, 0};
      vecs[7] = '{2049, 1'b1, 4, 2048, 'h800,  'hFFF,   0, 1, 65,  1, 5, 1, 1, 1};
      vecs[8] = '{MIN_FRAME_BYTES, 1'b1, 0, 64, 'h800, 'h83F, 1, 1, 64, 0, 6, 1, 1, 1};

      bus.Rx_Frame_Start = 1'b0;
      bus.Rx_Byte_Rdy    = 1'b0;
      bus.Rx_Byte        = 8'h00;
      bus.Rx_Frame_End   = 1'b0;
      bus.Crc_Ok         = 1'b0;
      bus.Frm_Ack        = 1'b0;

      #5;
      chk_zero_outputs("reset");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 9; v++) begin
         string tag;
         tag = $sformatf("vec%0d", v);
         for (int a = 0; a < vecs[v].acks; a++) ack_pulse();
         wr0 = wr_addr_log.size();
         dr0 = drop_total;
         send_frame(vecs[v].len, vecs[v].crc, 1'b0);
         @(negedge clk);
         n_wr = wr_addr_log.size() - wr0;
         chk({tag, ".nwr"}, n_wr, vecs[v].exp_wr);
         if (vecs[v].exp_wr > 0 && n_wr > 0) begin
            chk({tag, ".first"}, wr_addr_log[wr0], vecs[v].exp_first);
            chk({tag, ".last"}, wr_addr_log[wr0 + n_wr - 1], vecs[v].exp_last);
            chk({tag, ".data"}, wr_data_log[wr0 + n_wr - 1], ((vecs[v].exp_wr - 1) & 255) ^ 'hA5);
         end
         chk({tag, ".avail"}, int'(bus.Frm_Avail), vecs[v].exp_avail);
         chk({tag, ".slot"},  int'(bus.Frm_Slot),  vecs[v].exp_slot);
         chk({tag, ".len"},   int'(bus.Frm_Len),   vecs[v].exp_len);
         chk({tag, ".drops"}, drop_total - dr0,    vecs[v].exp_drops);
         chk_counters(tag, vecs[v].exp_good, vecs[v].exp_crc, vecs[v].exp_full, vecs[v].exp_ovf);
      end

      // ack lands in the commit cycle: occupancy stays at one, read pointer moves on
      wr0 = wr_addr_log.size();
      send_frame(70, 1'b1, 1'b1);
      @(negedge clk);
      chk("simul.first", wr_addr_log[wr0], 'h1000);
      chk("simul.avail", int'(bus.Frm_Avail), 1);
      chk("simul.slot",  int'(bus.Frm_Slot), 2);
      chk("simul.len",   int'(bus.Frm_Len), 70);
      ack_pulse();
      @(negedge clk);
      chk("simul.drain_avail", int'(bus.Frm_Avail), 0);
      chk("simul.drain_slot",  int'(bus.Frm_Slot), 3);
      ack_pulse();
      @(negedge clk);
      chk("ack_idle.slot", int'(bus.Frm_Slot), 3);
      chk_counters("simul", 7, 1, 1, 1);

      // reset mid-frame, then a clean frame must restart at slot 0 offset 0
      tick();
      bus.Rx_Frame_Start = 1'b1;
      tick();
      bus.Rx_Frame_Start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.Rx_Byte_Rdy = 1'b1;
         bus.Rx_Byte     = 8'(i) ^ 8'hA5;
         tick();
      end
      rst_n = 1'b0;
      #2;
      chk_zero_outputs("midrst");
      bus.Rx_Byte_Rdy = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      wr0 = wr_addr_log.size();
      send_frame(64, 1'b1, 1'b0);
      @(negedge clk);
      n_wr = wr_addr_log.size() - wr0;
      chk("postrst.nwr", n_wr, 64);
      if (n_wr > 0) begin
         chk("postrst.first", wr_addr_log[wr0], 'h000);
         chk("postrst.last",  wr_addr_log[wr0 + n_wr - 1], 'h03F);
      end
      chk("postrst.avail", int'(bus.Frm_Avail), 1);
      chk("postrst.slot",  int'(bus.Frm_Slot), 0);
      chk("postrst.len",   int'(bus.Frm_Len), 64);
      chk_counters("postrst", 1, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
